// File: rtl/prog_loader_if.sv
// Byte-stream handshake carrying program and checksum bytes into the loader.
interface prog_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             DIN_READY;

    modport master (
        output DIN,
        output DIN_VALID,
        input  DIN_READY
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        output DIN_READY
    );
endinterface

// File: rtl/prog_loader.sv
// Loadable 16x8 program RAM for the 4-bit CPU. Bytes stream into words
// 0..15 in order, followed by one checksum byte; the CPU is released only
// when the checksum matches the modulo-256 sum of the sixteen bytes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for START
// LOAD  | accepting program bytes into mem[cnt]
// CHECK | all 16 words written, waiting for the checksum byte
// RUN   | checksum matched, CPU_RUN high, memory frozen
// ERR   | checksum mismatch, LOAD_ERR high, CPU held in reset
module prog_loader #(
    parameter int WORDS = 16,
    parameter int WIDTH = 8
) (
    input  logic                     CK,
    input  logic                     RST_N,
    input  logic                     START,
    prog_loader_if.slave             din_if,
    input  logic [$clog2(WORDS)-1:0] AD,
    output logic [WIDTH-1:0]         Q,
    output logic                     CPU_RUN,
    output logic                     LOAD_ERR
);
    localparam int AW = $clog2(WORDS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_LAST = AW'(WORDS - 1);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] mem_d [WORDS];

    logic ready;
    logic accept;

    // Stream handshake: START always takes priority over a pending byte.
    always_comb begin
        ready  = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !START;
        accept = din_if.DIN_VALID && ready;
    end

    assign din_if.DIN_READY = ready;
    assign Q        = mem_q[AD];
    assign CPU_RUN  = (state_q == ST_RUN);
    assign LOAD_ERR = (state_q == ST_ERR);

    // Next-state, pointer, checksum and memory write decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        mem_d   = mem_q;
        if (START) begin
            // Memory is deliberately left alone; only the session bookkeeping restarts.
            state_d = ST_LOAD;
            cnt_d   = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        mem_d[cnt_q] = din_if.DIN;
                        sum_d        = sum_q + din_if.DIN;
                        cnt_d        = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        state_d = (din_if.DIN == sum_q) ? ST_RUN : ST_ERR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Control registers, cleared immediately on reset.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    // Program storage; reset zeroes every word so Q reads 00 until loaded.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: reset, vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based session model.
module tb_prog_loader;
    logic       CK;
    logic       RST_N;
    logic       START;
    logic [3:0] AD;
    logic [7:0] Q;
    logic       CPU_RUN;
    logic       LOAD_ERR;

    int errors = 0;
    int checks = 0;

    prog_loader_if #(.WIDTH(8)) bus ();

    prog_loader #(.WORDS(16), .WIDTH(8)) dut (
        .CK       (CK),
        .RST_N    (RST_N),
        .START    (START),
        .din_if   (bus.slave),
        .AD       (AD),
        .Q        (Q),
        .CPU_RUN  (CPU_RUN),
        .LOAD_ERR (LOAD_ERR)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] din;
        logic [3:0] ad;
        logic       exp_ready;
        logic       exp_run;
        logic       exp_err;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: bytes received in the current session.
    logic [7:0] sess_q[$];
    logic [7:0] m_mem [16];
    int         m_phase;   // 0 waiting, 1 collecting, 2 verified, 3 rejected

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic add_vec(input logic s, input logic v, input logic [7:0] d, input logic [3:0] a,
                           input logic er, input logic eru, input logic ee, input logic [7:0] eq);
        vec_t t;
        t.start = s; t.valid = v; t.din = d; t.ad = a;
        t.exp_ready = er; t.exp_run = eru; t.exp_err = ee; t.exp_q = eq;
        vecs.push_back(t);
    endtask

    task automatic idle_inputs();
        START = 1'b0;
        bus.DIN_VALID = 1'b0;
        bus.DIN = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        START = 1'b0;
        bus.DIN_VALID = 1'b1;
        bus.DIN = b;
        tick();
        bus.DIN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    function automatic logic [7:0] sess_sum();
        logic [7:0] s = 8'h00;
        foreach (sess_q[i]) s = s + sess_q[i];
        return s;
    endfunction

    logic [7:0] gl [16];

    initial begin
        RST_N = 1'b1;
        AD = 4'd0;
        idle_inputs();
        #2;
        RST_N = 1'b0;
        #1;
        // Immediate reset state
        chk("rst_ready", {31'd0, bus.DIN_READY}, 32'd0);
        chk("rst_run",   {31'd0, CPU_RUN}, 32'd0);
        chk("rst_err",   {31'd0, LOAD_ERR}, 32'd0);
        tick();
        RST_N = 1'b1;
        tick();

        // ---------- vector table ----------
        gl[0] = 8'h30; gl[1] = 8'h50; gl[2] = 8'h90; gl[3] = 8'hB3;
        for (int i = 4; i < 16; i++) gl[i] = 8'h00;

        // good load, checksum C3
        add_vec(1, 0, 8'h00, 4'd0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) add_vec(0, 1, gl[i], 4'(i), 1, 0, 0, gl[i]);
        add_vec(0, 1, 8'hC3, 4'd3, 1, 1, 0, 8'hB3);
        add_vec(0, 1, 8'h77, 4'd4, 0, 1, 0, 8'h00);
        // START from RUN: run falls, memory retained
        add_vec(1, 1, 8'h55, 4'd3, 0, 0, 0, 8'hB3);
        // bad checksum C4
        for (int i = 0; i < 16; i++) add_vec(0, 1, gl[i], 4'(i), 1, 0, 0, gl[i]);
        add_vec(0, 1, 8'hC4, 4'd3, 1, 0, 1, 8'hB3);
        add_vec(0, 1, 8'hC3, 4'd0, 0, 0, 1, 8'h30);
        // START clears LOAD_ERR; ready returns
        add_vec(1, 0, 8'h00, 4'd1, 0, 0, 0, 8'h50);
        add_vec(0, 0, 8'h00, 4'd2, 1, 0, 0, 8'h90);

        foreach (vecs[k]) begin
            START = vecs[k].start;
            bus.DIN_VALID = vecs[k].valid;
            bus.DIN = vecs[k].din;
            AD = vecs[k].ad;
            #1;
            chk($sformatf("vec%0d_ready", k), {31'd0, bus.DIN_READY}, {31'd0, vecs[k].exp_ready});
            tick();
            chk($sformatf("vec%0d_run", k), {31'd0, CPU_RUN}, {31'd0, vecs[k].exp_run});
            chk($sformatf("vec%0d_err", k), {31'd0, LOAD_ERR}, {31'd0, vecs[k].exp_err});
            chk($sformatf("vec%0d_q", k), {24'd0, Q}, {24'd0, vecs[k].exp_q});
        end
        idle_inputs();

        // ---------- reset mid-session ----------
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, bus.DIN_READY}, 32'd0);
        chk("midrst_run",   {31'd0, CPU_RUN}, 32'd0);
        chk("midrst_err",   {31'd0, LOAD_ERR}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            AD = 4'(a);
            #1;
            chk($sformatf("midrst_q%0d", a), {24'd0, Q}, 32'd0);
        end
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.DIN_VALID = 1'b1; bus.DIN = 8'h5A; AD = 4'd0;
            #1;
            chk("postrst_ready", {31'd0, bus.DIN_READY}, 32'd0);
            tick();
            chk("postrst_q", {24'd0, Q}, 32'd0);
        end
        idle_inputs();

        // ---------- gaps and wrap ----------
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'hFF);
            repeat ($urandom_range(0, 3)) tick();
        end
        chk("gap_not_run_early", {31'd0, CPU_RUN}, 32'd0);
        send_byte(8'hF0);
        chk("gap_run", {31'd0, CPU_RUN}, 32'd1);
        chk("gap_err", {31'd0, LOAD_ERR}, 32'd0);
        bus.DIN_VALID = 1'b1; bus.DIN = 8'h12; AD = 4'd0;
        #1;
        chk("gap_ready_in_run", {31'd0, bus.DIN_READY}, 32'd0);
        tick();
        chk("gap_frozen_q0", {24'd0, Q}, 32'hFF);
        idle_inputs();

        // ---------- restart with colliding byte ----------
        START = 1'b1; tick(); START = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h22);
        START = 1'b1; bus.DIN_VALID = 1'b1; bus.DIN = 8'hAA;
        #1;
        chk("restart_ready", {31'd0, bus.DIN_READY}, 32'd0);
        tick();
        idle_inputs();
        for (int i = 0; i < 16; i++) send_byte(8'h11);
        chk("restart_not_run_early", {31'd0, CPU_RUN}, 32'd0);
        send_byte(8'h10);
        chk("restart_run", {31'd0, CPU_RUN}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            AD = 4'(a);
            #1;
            chk($sformatf("restart_mem%0d", a), {24'd0, Q}, 32'h11);
        end

        // ---------- randomized traffic vs session model ----------
        do_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        sess_q.delete();
        m_phase = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic s, v, exp_rdy;
            logic [7:0] d;
            s = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (m_phase == 1 && sess_q.size() == 16 && $urandom_range(0, 3) != 0) d = sess_sum();
            START = s; bus.DIN_VALID = v; bus.DIN = d; AD = 4'($urandom);
            exp_rdy = (m_phase == 1) && !s;
            #1;
            chk("rnd_ready", {31'd0, bus.DIN_READY}, {31'd0, exp_rdy});
            tick();
            if (s) begin
                m_phase = 1;
                sess_q.delete();
            end else if (v && exp_rdy) begin
                if (sess_q.size() < 16) begin
                    m_mem[sess_q.size()] = d;
                    sess_q.push_back(d);
                end else begin
                    m_phase = (d == sess_sum()) ? 2 : 3;
                end
            end
            chk("rnd_run", {31'd0, CPU_RUN}, {31'd0, m_phase == 2});
            chk("rnd_err", {31'd0, LOAD_ERR}, {31'd0, m_phase == 3});
            chk("rnd_q", {24'd0, Q}, {24'd0, m_mem[AD]});
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory writer for the 4-bit CPU. It replaces the fixed 16×8 instruction ROM with a loadable 16×8 RAM. Program bytes arrive over a valid/ready byte stream and are written to words 0..15 in order. The program is released to the CPU only after a trailing checksum byte verifies. The CPU fetches through the same combinational read port as before (AD in, Q out), and `CPU_RUN` gates the CPU (held in reset while low).

## Interface
Parameters:
- `WORDS`, 16: program words; fixed to match the 4-bit PC.
- `WIDTH`, 8: instruction width ({OP[3:0], IM[3:0]}).

Ports:
- `CK`  input  1  clock; all state changes on the rising edge.
- `RST_N`  input  1  reset, asynchronous, active-low.
- `START`  input  1  one-cycle request to begin a load session.
- `DIN`  input  8  program or checksum byte.
- `DIN_VALID`  input  1  `DIN` holds a byte.
- `DIN_READY`  output  1  loader accepts `DIN` this cycle.
- `AD`  input  4  CPU fetch address (PC output).
- `Q`  output  8  instruction word at `AD`.
- `CPU_RUN`  output  1  high: program verified, CPU may execute.
- `LOAD_ERR`  output  1  high: last session failed the checksum.

## Operation
- Storage: 16×8 register array, `mem[0..15]`, written only by the loader.
- Read path: `Q = mem[AD]`, combinational, in every state. Bench readback works without running the CPU.
- Internal registers:
  - `state`: IDLE, LOAD, CHECK, RUN, ERR.
  - `cnt[3:0]`: write pointer.
  - `sum[7:0]`: running checksum.
- Accept: a byte is accepted at a rising `CK` when `DIN_VALID && DIN_READY`.
- `DIN_READY` = (state is LOAD or CHECK) && !`START`.
- State behaviour:
  - IDLE: waits for `START`.
  - LOAD: on accept, `mem[cnt] <= DIN`, `sum <= sum + DIN` (mod 256), `cnt <= cnt + 1`. The accept with `cnt` = 15 moves to CHECK; `cnt` wraps to 0.
  - CHECK: on accept, go to RUN if `DIN == sum`, otherwise go to ERR. The checksum byte is never written to `mem`.
  - RUN: `CPU_RUN` = 1. Memory is frozen and incoming bytes are not accepted.
  - ERR: `LOAD_ERR` = 1. Memory keeps the partially verified contents, and `CPU_RUN` stays 0.
- `START`, in any state, takes effect at the next edge:
  - state goes to LOAD;
  - `cnt` and `sum` are cleared to 0;
  - `LOAD_ERR` and `CPU_RUN` are cleared.
  - Memory is not cleared. Unsent words keep their old values, but the checksum covers exactly the 16 bytes sent in the session.
- `START` together with `DIN_VALID` in the same cycle: `START` wins and the byte is not accepted (`DIN_READY` is 0).
- Idle cycles (`DIN_VALID` = 0) in LOAD or CHECK hold all state. There is no timeout.

## Timing
- Reset (`RST_N` low, asynchronous, effective immediately, including mid-session):
  - state = IDLE, `cnt` = 0, `sum` = 0, all `mem` words = 8'h00.
  - `DIN_READY` = 0, `CPU_RUN` = 0, `LOAD_ERR` = 0, so `Q` = 8'h00.
- Release: synchronous. The first edge with `RST_N` high evaluates `START` normally.
- Outputs are decoded from registered state only; none depends combinationally on `DIN`.
  - `CPU_RUN` = (state == RUN).
  - `LOAD_ERR` = (state == ERR).
  - `DIN_READY` has the single combinational term `!START`.
- Latency:
  - A write is visible on `Q` (with `AD` = that word) immediately after its accept edge.
  - `CPU_RUN` rises immediately after the checksum-accept edge.
  - `DIN_READY` is high from the edge after `START`.
- Minimum session: 1 `START` cycle + 17 accept cycles. `CPU_RUN` is high in the 19th cycle counted from the `START` cycle.
- `CPU_RUN` falls immediately after the edge that samples `START` or at `RST_N` low. The CPU's PC restarts from 0 on its next release.

## Test plan
- Reset: pulse `RST_N` low after 5 bytes of a session.
  - Immediately: `DIN_READY` = 0, `CPU_RUN` = 0, `LOAD_ERR` = 0, and `Q` = 8'h00 for every `AD`.
  - Edges with `DIN_VALID` high and no `START` are ignored.
- Good load: `START`, then 8'h30, 8'h50, 8'h90, 8'hB3, twelve 8'h00 bytes, then checksum 8'hC3.
  - `CPU_RUN` = 1 right after the last edge, `LOAD_ERR` = 0.
  - `Q` = 8'hB3 at `AD` = 3 and 8'h00 at `AD` = 4.
  - With the CPU attached, the out register reaches 4'b0011.
- Bad checksum: same 16 bytes, checksum 8'hC4.
  - `LOAD_ERR` = 1, `CPU_RUN` = 0, `DIN_READY` = 0.
  - A following `START` clears `LOAD_ERR` at the next edge and `DIN_READY` = 1.
- Gaps and wrap: sixteen 8'hFF bytes with 0–3 idle cycles between them, checksum 8'hF0 (4080 mod 256).
  - Ends in RUN.
  - No extra bytes are accepted and no byte is counted twice.
- Restart: after 5 bytes, assert `START` with `DIN_VALID` = 1 and `DIN` = 8'hAA.
  - The byte is not accepted and `cnt` restarts at 0.
  - A full load of sixteen 8'h11 bytes plus checksum 8'h10 succeeds, and `mem[0..15]` = 8'h11.
- `START` in RUN: `CPU_RUN` falls right after the sampling edge, state is LOAD, and memory keeps its contents until overwritten.
